// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the icache/dcache physical-memory arbiter.
package cache_arb_types;

  localparam int unsigned LINE_WIDTH = 256;
  localparam int unsigned STREAK_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } arb_state_t;

  typedef logic [LINE_WIDTH-1:0] line_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of icache, dcache and pmem signals around the arbiter.
// The slave modport is the arbiter; master is the caches plus memory.
interface cache_mem_arbiter_if #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Grants the single pmem port to the icache or dcache, one transaction at a time.
// Dcache wins ties until a bounded streak forces an icache grant.
module cache_mem_arbiter #(
  parameter int unsigned LINE_WIDTH   = 256,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  cache_mem_arbiter_if.slave  bus
);

  import cache_arb_types::*;

  arb_state_t            state_q;
  logic [STREAK_W-1:0]   streak_q;
  logic                  read_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic i_req;
  logic d_req;
  logic d_wins;

  always_comb begin
    i_req  = bus.i_pmem_read;
    d_req  = bus.d_pmem_read | bus.d_pmem_write;
    d_wins = d_req && (!i_req || (streak_q < STREAK_W'(MAX_D_STREAK)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (d_wins) begin
            state_q <= D_BUSY;
            addr_q  <= bus.d_pmem_address;
            wdata_q <= bus.d_pmem_wdata;
            // Read takes precedence if a cache ever raises both strobes.
            read_q  <= bus.d_pmem_read;
            write_q <= bus.d_pmem_write & ~bus.d_pmem_read;
            if (!i_req) begin
              streak_q <= '0;
            end else if (streak_q != '1) begin
              streak_q <= streak_q + 1'b1;
            end
          end else if (i_req) begin
            state_q  <= I_BUSY;
            addr_q   <= bus.i_pmem_address;
            wdata_q  <= '0;
            read_q   <= 1'b1;
            write_q  <= 1'b0;
            streak_q <= '0;
          end
        end
        I_BUSY, D_BUSY: begin
          // Leaving through IDLE guarantees one idle cycle between transactions.
          if (bus.pmem_resp) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.d_pmem_read && bus.d_pmem_write))
        else $warning("illegal: dcache raised read and write together");
    end
  end

  assign bus.pmem_read    = read_q;
  assign bus.pmem_write   = write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;
  assign bus.i_pmem_resp  = (state_q == I_BUSY) && bus.pmem_resp;
  assign bus.d_pmem_resp  = (state_q == D_BUSY) && bus.pmem_resp;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench: expected pmem transactions are queued when requests are raised
// and checked as the arbiter presents them to the memory model.
module tb_cache_mem_arbiter;

  import cache_arb_types::*;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  typedef struct packed {
    logic          is_d;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  cache_mem_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

  cache_mem_arbiter #(
    .LINE_WIDTH  (LW),
    .ADDR_WIDTH  (AW),
    .MAX_D_STREAK(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Memory model: wait for a strobe, compare it against the scoreboard head,
  // hold for lat cycles, then respond with data.
  task automatic serve(input string tag, input int exp_wait, input int lat,
                       input logic [LW-1:0] data);
    exp_t e;
    int   waited = 0;
    while (!(bus.pmem_read || bus.pmem_write) && waited < 40) begin
      tick();
      waited++;
    end
    if (waited >= 40) begin
      check({tag, "_grant_timeout"}, 0, 1);
      return;
    end
    if (exp_wait >= 0) check({tag, "_grant_latency"}, waited, exp_wait);
    if (sb.size() == 0) begin
      check({tag, "_unexpected_txn"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_addr"}, bus.pmem_address, e.addr);
    check({tag, "_read"}, bus.pmem_read, e.rd);
    check({tag, "_write"}, bus.pmem_write, e.wr);
    if (e.wr) check({tag, "_wdata"}, bus.pmem_wdata, e.wdata);
    repeat (lat) begin
      tick();
      check({tag, "_hold"}, {bus.pmem_read, bus.pmem_write, bus.pmem_address},
            {e.rd, e.wr, e.addr});
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = data;
    #1;
    check({tag, "_i_resp"}, bus.i_pmem_resp, !e.is_d);
    check({tag, "_d_resp"}, bus.d_pmem_resp, e.is_d);
    if (e.rd) begin
      if (e.is_d) check({tag, "_d_rdata"}, bus.d_pmem_rdata, data);
      else        check({tag, "_i_rdata"}, bus.i_pmem_rdata, data);
    end
    tick();
    bus.pmem_resp = 1'b0;
    #1;
    check({tag, "_strobe_drop"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
    check({tag, "_resp_pulse"}, {bus.i_pmem_resp, bus.d_pmem_resp}, 2'b00);
  endtask

  initial begin
    logic [LW-1:0] a5_line;
    logic [LW-1:0] dead_line;
    a5_line   = {32{8'hA5}};
    dead_line = {8{32'hDEADBEEF}};

    rst                = 1'b1;
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.pmem_rdata     = '0;
    bus.pmem_resp      = 1'b0;
    repeat (3) tick();

    check("rst_pmem_read", bus.pmem_read, 0);
    check("rst_pmem_write", bus.pmem_write, 0);
    check("rst_pmem_address", bus.pmem_address, 0);
    check("rst_pmem_wdata", bus.pmem_wdata, 0);
    check("rst_resps", {bus.i_pmem_resp, bus.d_pmem_resp}, 0);
    check("rst_state", dut.state_q, IDLE);
    check("rst_streak", dut.streak_q, 0);
    rst = 1'b0;
    tick();

    // Icache-only read: strobe from cycle 1, resp in cycle 5.
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h60;
    sb.push_back('{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h60, wdata: '0});
    serve("iread", 1, 4, a5_line);
    bus.i_pmem_read = 1'b0;
    tick();

    // Dcache writeback.
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h1000;
    bus.d_pmem_wdata   = dead_line;
    sb.push_back('{is_d: 1'b1, rd: 1'b0, wr: 1'b1, addr: 32'h1000, wdata: dead_line});
    serve("dwb", 1, 3, '0);
    bus.d_pmem_write = 1'b0;
    tick();

    // Simultaneous requests: dcache first, icache in the following IDLE cycle.
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h40;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h2000;
    sb.push_back('{is_d: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'h2000, wdata: '0});
    sb.push_back('{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h40, wdata: '0});
    serve("sim_d", 1, 2, {8{32'h1111_2222}});
    bus.d_pmem_read = 1'b0;
    serve("sim_i", 1, 2, {8{32'h3333_4444}});
    bus.i_pmem_read = 1'b0;
    tick();

    // Starvation guard: four dcache grants, then the pending icache.
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h80;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h3000;
    for (int k = 0; k < 4; k++)
      sb.push_back('{is_d: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'h3000, wdata: '0});
    sb.push_back('{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h80, wdata: '0});
    for (int k = 0; k < 4; k++) serve("streak_d", 1, 1, LW'(k + 1));
    check("streak_at_max", dut.streak_q, 4);
    serve("streak_i", 1, 1, {8{32'hCAFE_F00D}});
    check("streak_cleared", dut.streak_q, 0);
    bus.i_pmem_read = 1'b0;
    bus.d_pmem_read = 1'b0;
    tick();
    check("sb_drained", sb.size(), 0);

    // Reset in the middle of a dcache read, then a late memory response.
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h4000;
    tick();
    tick();
    check("midrst_strobe_up", bus.pmem_read, 1);
    rst = 1'b1;
    tick();
    check("midrst_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
    rst             = 1'b0;
    bus.d_pmem_read = 1'b0;
    tick();
    bus.pmem_resp = 1'b1;
    #1;
    check("late_resp_blocked", {bus.i_pmem_resp, bus.d_pmem_resp}, 2'b00);
    tick();
    bus.pmem_resp = 1'b0;
    check("late_resp_state", dut.state_q, IDLE);
    check("late_resp_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
    tick();

    // Illegal read+write from the dcache: read wins.
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h5000;
    bus.d_pmem_wdata   = {8{32'h0BAD_0BAD}};
    sb.push_back('{is_d: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'h5000, wdata: '0});
    serve("rw_both", 1, 0, {8{32'h5A5A_5A5A}});
    bus.d_pmem_read  = 1'b0;
    bus.d_pmem_write = 1'b0;
    tick();
    tick();
    check("final_idle", dut.state_q, IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
